// File: rtl/ifu_fetch_unit.sv
// Non-pipelined instruction fetch: one AXI4-Lite read per instruction, then hand
// the word to decode and wait for write-back to supply the next PC.
module ifu_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  output logic        ifu_valid,
  input  logic        idu_ready,
  output logic [31:0] inst,
  output logic [31:0] ifu_to_idu_pc,
  output logic        ifu_fault,
  input  logic        next_pc_valid,
  input  logic [31:0] next_pc,
  output logic [31:0] fetch_count,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    S_AR   = 2'd0,
    S_R    = 2'd1,
    S_OUT  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        fault_q, fault_d;
  logic [31:0] cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_AR;
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
      fault_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_AR: if (arready) state_d = S_R;
      S_R: if (rvalid) begin
        inst_d  = rdata;
        fault_d = (rresp != 2'b00);
        state_d = S_OUT;
      end
      S_OUT: if (idu_ready) begin
        cnt_d   = cnt_q + 32'd1;
        state_d = S_WAIT;
      end
      S_WAIT: if (next_pc_valid) begin
        pc_d = next_pc;
        // A misaligned target never reaches the bus; decode sees a faulted slot.
        if (next_pc[1:0] == 2'b00) begin
          state_d = S_AR;
        end else begin
          inst_d  = 32'd0;
          fault_d = 1'b1;
          state_d = S_OUT;
        end
      end
      default: state_d = S_AR;
    endcase
  end

  assign arvalid       = (state_q == S_AR);
  assign rready        = (state_q == S_R);
  assign ifu_valid     = (state_q == S_OUT);
  assign araddr        = pc_q;
  assign ifu_to_idu_pc = pc_q;
  assign inst          = inst_q;
  assign ifu_fault     = fault_q;
  assign fetch_count   = cnt_q;
  assign state_out     = state_q;

endmodule
